// File: rtl/fft_pkg.sv
// Shared constants and helpers for the fft accelerator family.
// Bin words pack a signed real part in the upper half and a signed
// imaginary part in the lower half of the stream word.
package fft_pkg;

    // Default bins per frame; must match the fft core's SIZE.
    localparam int FFT_SIZE       = 8;

    // Default stream word width and the width of each complex component.
    localparam int FFT_DATA_WIDTH = 32;
    localparam int FFT_HALF_WIDTH = FFT_DATA_WIDTH / 2;

    // Field positions of the real/imaginary parts for the default width.
    localparam int FFT_RE_MSB     = FFT_DATA_WIDTH - 1;
    localparam int FFT_RE_LSB     = FFT_HALF_WIDTH;
    localparam int FFT_IM_MSB     = FFT_HALF_WIDTH - 1;
    localparam int FFT_IM_LSB     = 0;

    // Ceiling log2, usable in parameter defaults (returns 0 for value <= 1).
    function automatic int fft_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Half of a stream word width: the width of one complex component.
    function automatic int fft_half_width(input int data_width);
        return data_width / 2;
    endfunction

endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage signed squarer-adder: S1 holds re^2 and im^2, S2 holds their
// unsigned sum. A side-band index and last tag ride along with each word.
// Every stage advances only when en is high, so the whole pipe freezes
// together under back-pressure.
module fft_mag_sq
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = FFT_DATA_WIDTH,
    parameter int TAG_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [TAG_WIDTH-1:0]  in_idx,
    input  logic                  in_last,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]  out_idx,
    output logic                  out_last
);

    localparam int HALF = fft_half_width(DATA_WIDTH);

    // Component extraction and squaring (combinational, feeds S1).
    logic signed [HALF-1:0]       re_s;
    logic signed [HALF-1:0]       im_s;
    logic signed [DATA_WIDTH-1:0] re_ext_s;
    logic signed [DATA_WIDTH-1:0] im_ext_s;
    logic signed [DATA_WIDTH-1:0] re_sq_s;
    logic signed [DATA_WIDTH-1:0] im_sq_s;

    // S1 registers.
    logic                  v1_q,     v1_d;
    logic [DATA_WIDTH-1:0] re_sq_q,  re_sq_d;
    logic [DATA_WIDTH-1:0] im_sq_q,  im_sq_d;
    logic [TAG_WIDTH-1:0]  idx1_q,   idx1_d;
    logic                  last1_q,  last1_d;

    // S2 registers (drive the outputs directly).
    logic                  v2_q,     v2_d;
    logic [DATA_WIDTH-1:0] sum_q,    sum_d;
    logic [TAG_WIDTH-1:0]  idx2_q,   idx2_d;
    logic                  last2_q,  last2_d;

    // Split the bin word and square each component at full word width;
    // the largest square, (-2^(HALF-1))^2 = 2^(DATA_WIDTH-2), fits signed.
    always_comb begin
        re_s     = in_data[DATA_WIDTH-1:HALF];
        im_s     = in_data[HALF-1:0];
        re_ext_s = {{HALF{re_s[HALF-1]}}, re_s};
        im_ext_s = {{HALF{im_s[HALF-1]}}, im_s};
        re_sq_s  = re_ext_s * re_ext_s;
        im_sq_s  = im_ext_s * im_ext_s;
    end

    // S1 next state: capture squares and side-band when the pipe advances.
    always_comb begin
        v1_d    = v1_q;
        re_sq_d = re_sq_q;
        im_sq_d = im_sq_q;
        idx1_d  = idx1_q;
        last1_d = last1_q;
        if (en) begin
            v1_d    = in_valid;
            re_sq_d = $unsigned(re_sq_s);
            im_sq_d = $unsigned(im_sq_s);
            idx1_d  = in_idx;
            last1_d = in_last;
        end else begin
            v1_d    = v1_q;
            re_sq_d = re_sq_q;
            im_sq_d = im_sq_q;
            idx1_d  = idx1_q;
            last1_d = last1_q;
        end
    end

    // S2 next state: the sum of two non-negative squares peaks at
    // 2^(DATA_WIDTH-1), so an unsigned DATA_WIDTH-bit add never wraps.
    always_comb begin
        v2_d    = v2_q;
        sum_d   = sum_q;
        idx2_d  = idx2_q;
        last2_d = last2_q;
        if (en) begin
            v2_d    = v1_q;
            sum_d   = re_sq_q + im_sq_q;
            idx2_d  = idx1_q;
            last2_d = last1_q;
        end else begin
            v2_d    = v2_q;
            sum_d   = sum_q;
            idx2_d  = idx2_q;
            last2_d = last2_q;
        end
    end

    // Pipeline registers with synchronous reset clearing valids and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            re_sq_q <= {DATA_WIDTH{1'b0}};
            im_sq_q <= {DATA_WIDTH{1'b0}};
            idx1_q  <= {TAG_WIDTH{1'b0}};
            last1_q <= 1'b0;
            v2_q    <= 1'b0;
            sum_q   <= {DATA_WIDTH{1'b0}};
            idx2_q  <= {TAG_WIDTH{1'b0}};
            last2_q <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            re_sq_q <= re_sq_d;
            im_sq_q <= im_sq_d;
            idx1_q  <= idx1_d;
            last1_q <= last1_d;
            v2_q    <= v2_d;
            sum_q   <= sum_d;
            idx2_q  <= idx2_d;
            last2_q <= last2_d;
        end
    end

    assign out_valid = v2_q;
    assign out_data  = sum_q;
    assign out_idx   = idx2_q;
    assign out_last  = last2_q;

endmodule

// File: rtl/fft_mag_peak.sv
// Squared-magnitude and peak-bin stage behind the fft core.
// Consumes complex bins on s00, emits re^2+im^2 per bin on m00, and at
// each frame end pulses peak_valid with the frame's largest bin (lowest
// index wins ties). frame_err latches any tlast/bin-count disagreement.
module fft_mag_peak
    import fft_pkg::*;
#(
    parameter int SIZE       = FFT_SIZE,
    parameter int DATA_WIDTH = FFT_DATA_WIDTH,
    parameter int IDX_WIDTH  = fft_clog2(SIZE)
) (
    input  logic                      s00_axi_aclk,
    input  logic                      s00_axi_areset,
    input  logic [DATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic                      s00_axis_tvalid,
    input  logic                      s00_axis_tlast,
    output logic                      s00_axis_tready,
    output logic [DATA_WIDTH-1:0]     m00_axis_tdata,
    output logic                      m00_axis_tvalid,
    output logic [DATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                      m00_axis_tlast,
    input  logic                      m00_axis_tready,
    output logic                      peak_valid,
    output logic [IDX_WIDTH-1:0]      peak_idx,
    output logic [DATA_WIDTH-1:0]     peak_mag,
    output logic                      frame_err
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(SIZE - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_ONE  = IDX_WIDTH'(1);

    // Handshake / control.
    logic                  en_s;
    logic                  s_ready_s;
    logic                  in_hs_s;
    logic                  at_end_s;
    logic                  last_tag_s;
    logic                  out_hs_s;

    // Pipeline outputs from the datapath.
    logic                  m_valid_s;
    logic [DATA_WIDTH-1:0] m_data_s;
    logic [IDX_WIDTH-1:0]  m_idx_s;
    logic                  m_last_s;

    // Peak candidate after considering the word on the output port.
    logic                  take_s;
    logic [DATA_WIDTH-1:0] cand_mag_s;
    logic [IDX_WIDTH-1:0]  cand_idx_s;

    // State.
    logic [IDX_WIDTH-1:0]  cnt_q,        cnt_d;
    logic                  frame_err_q,  frame_err_d;
    logic [DATA_WIDTH-1:0] run_mag_q,    run_mag_d;
    logic [IDX_WIDTH-1:0]  run_idx_q,    run_idx_d;
    logic                  peak_valid_q, peak_valid_d;
    logic [IDX_WIDTH-1:0]  peak_idx_q,   peak_idx_d;
    logic [DATA_WIDTH-1:0] peak_mag_q,   peak_mag_d;

    // Global advance: the pipe moves whenever the output slot is empty or
    // being taken; input is refused for the whole reset cycle.
    always_comb begin
        en_s       = !m_valid_s || m00_axis_tready;
        s_ready_s  = en_s && !s00_axi_areset;
        in_hs_s    = s00_axis_tvalid && s_ready_s;
        out_hs_s   = m_valid_s && m00_axis_tready;
        at_end_s   = (cnt_q == LAST_IDX);
        last_tag_s = at_end_s || s00_axis_tlast;
    end

    // Bin counter and sticky frame error: a frame ends on either the count
    // reaching SIZE-1 or an input tlast; disagreement between the two is an error.
    always_comb begin
        cnt_d       = cnt_q;
        frame_err_d = frame_err_q;
        if (in_hs_s) begin
            if (last_tag_s) begin
                cnt_d = {IDX_WIDTH{1'b0}};
            end else begin
                cnt_d = cnt_q + IDX_ONE;
            end
            if (s00_axis_tlast != at_end_s) begin
                frame_err_d = 1'b1;
            end else begin
                frame_err_d = frame_err_q;
            end
        end else begin
            cnt_d       = cnt_q;
            frame_err_d = frame_err_q;
        end
    end

    // Running max candidate: bin 0 always restarts the search, later bins
    // win only when strictly larger so ties keep the earlier index.
    always_comb begin
        take_s = (m_idx_s == {IDX_WIDTH{1'b0}}) || (m_data_s > run_mag_q);
        if (take_s) begin
            cand_mag_s = m_data_s;
            cand_idx_s = m_idx_s;
        end else begin
            cand_mag_s = run_mag_q;
            cand_idx_s = run_idx_q;
        end
    end

    // Peak tracking on the output handshake; the last word publishes the
    // frame's winner and raises a one-cycle peak_valid.
    always_comb begin
        run_mag_d    = run_mag_q;
        run_idx_d    = run_idx_q;
        peak_valid_d = 1'b0;
        peak_idx_d   = peak_idx_q;
        peak_mag_d   = peak_mag_q;
        if (out_hs_s) begin
            run_mag_d = cand_mag_s;
            run_idx_d = cand_idx_s;
            if (m_last_s) begin
                peak_valid_d = 1'b1;
                peak_idx_d   = cand_idx_s;
                peak_mag_d   = cand_mag_s;
            end else begin
                peak_valid_d = 1'b0;
                peak_idx_d   = peak_idx_q;
                peak_mag_d   = peak_mag_q;
            end
        end else begin
            run_mag_d    = run_mag_q;
            run_idx_d    = run_idx_q;
            peak_valid_d = 1'b0;
        end
    end

    // Control and peak registers with synchronous reset.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            cnt_q        <= {IDX_WIDTH{1'b0}};
            frame_err_q  <= 1'b0;
            run_mag_q    <= {DATA_WIDTH{1'b0}};
            run_idx_q    <= {IDX_WIDTH{1'b0}};
            peak_valid_q <= 1'b0;
            peak_idx_q   <= {IDX_WIDTH{1'b0}};
            peak_mag_q   <= {DATA_WIDTH{1'b0}};
        end else begin
            cnt_q        <= cnt_d;
            frame_err_q  <= frame_err_d;
            run_mag_q    <= run_mag_d;
            run_idx_q    <= run_idx_d;
            peak_valid_q <= peak_valid_d;
            peak_idx_q   <= peak_idx_d;
            peak_mag_q   <= peak_mag_d;
        end
    end

    fft_mag_sq #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_WIDTH  (IDX_WIDTH)
    ) u_mag_sq (
        .clk       (s00_axi_aclk),
        .rst       (s00_axi_areset),
        .en        (en_s),
        .in_valid  (in_hs_s),
        .in_data   (s00_axis_tdata),
        .in_idx    (cnt_q),
        .in_last   (last_tag_s),
        .out_valid (m_valid_s),
        .out_data  (m_data_s),
        .out_idx   (m_idx_s),
        .out_last  (m_last_s)
    );

    assign s00_axis_tready = s_ready_s;
    assign m00_axis_tvalid = m_valid_s;
    assign m00_axis_tdata  = m_data_s;
    assign m00_axis_tlast  = m_last_s;
    assign m00_axis_tstrb  = {(DATA_WIDTH/8){1'b1}};
    assign peak_valid      = peak_valid_q;
    assign peak_idx        = peak_idx_q;
    assign peak_mag        = peak_mag_q;
    assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_fft_mag_peak.sv
// Self-checking bench for fft_mag_peak (SIZE=4): directed scenarios plus a
// randomized run, all scored against a frame-level reference model.
module tb_fft_mag_peak;

    localparam int SIZE = 4;
    localparam int DW   = 32;
    localparam int IW   = 2;

    logic            clk = 1'b0;
    logic            areset;
    logic [DW-1:0]   s_tdata;
    logic            s_tvalid;
    logic            s_tlast;
    logic            s_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid;
    logic [DW/8-1:0] m_tstrb;
    logic            m_tlast;
    logic            m_tready;
    logic            peak_valid;
    logic [IW-1:0]   peak_idx;
    logic [DW-1:0]   peak_mag;
    logic            frame_err;

    always #5 clk = ~clk;

    fft_mag_peak #(.SIZE(SIZE), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_areset  (areset),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tready (s_tready),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tstrb  (m_tstrb),
        .m00_axis_tlast  (m_tlast),
        .m00_axis_tready (m_tready),
        .peak_valid      (peak_valid),
        .peak_idx        (peak_idx),
        .peak_mag        (peak_mag),
        .frame_err       (frame_err)
    );

    typedef struct {
        logic [31:0] mag;
        logic        last;
        int          pidx;
        logic [31:0] pmag;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] frame_mags[$];
    int          cnt_m = 0;
    logic        err_m = 1'b0;
    logic        pend_m = 1'b0;
    int          pend_idx = 0;
    logic [31:0] pend_mag = 32'd0;
    int          pk_idx_m = 0;
    logic [31:0] pk_mag_m = 32'd0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int first_acc_cyc = -1;
    int first_out_cyc = -1;
    int out_count = 0;
    int out_first = -1;
    int out_last_c = -1;
    int peak_cycles[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Squared magnitude straight from the bin definition.
    function automatic logic [31:0] mag_of(input logic [31:0] w);
        longint re;
        longint im;
        re = longint'($signed(w[31:16]));
        im = longint'($signed(w[15:0]));
        return 32'(re * re + im * im);
    endfunction

    // One clock: drive at negedge, score handshakes before the edge,
    // check registered side-band after it.
    task automatic cycle(input logic vld, input logic [31:0] data, input logic lst,
                         input logic rdy, input logic rst, input logic exp_stall,
                         output logic accepted);
        exp_t e;
        int   best;
        logic lt;
        s_tvalid = vld;
        s_tdata  = data;
        s_tlast  = lst;
        m_tready = rdy;
        areset   = rst;
        #1;
        accepted = 1'b0;
        if (rst) check_val("tready_in_reset", {31'd0, s_tready}, 32'd0);
        else if (rdy) check_val("tready_follow", {31'd0, s_tready}, 32'd1);
        else if (exp_stall) check_val("tready_stall", {31'd0, s_tready}, 32'd0);
        if (!rst) begin
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_out", {31'd0, m_tvalid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("mag", m_tdata, e.mag);
                    check_val("tlast_out", {31'd0, m_tlast}, {31'd0, e.last});
                    if (e.last) begin
                        pend_m   = 1'b1;
                        pend_idx = e.pidx;
                        pend_mag = e.pmag;
                    end
                    if (first_out_cyc < 0) first_out_cyc = cyc;
                    if (out_first < 0) out_first = cyc;
                    out_count++;
                    out_last_c = cyc;
                end
            end
            if (s_tvalid && s_tready) begin
                accepted = 1'b1;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                lt = (cnt_m == SIZE - 1) || lst;
                if (lst != (cnt_m == SIZE - 1)) err_m = 1'b1;
                frame_mags.push_back(mag_of(data));
                e.mag  = mag_of(data);
                e.last = lt;
                e.pidx = 0;
                e.pmag = 32'd0;
                if (lt) begin
                    best = 0;
                    for (int i = 1; i < frame_mags.size(); i++)
                        if (frame_mags[i] > frame_mags[best]) best = i;
                    e.pidx = best;
                    e.pmag = frame_mags[best];
                    frame_mags.delete();
                    cnt_m = 0;
                end else begin
                    cnt_m++;
                end
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            exp_q.delete();
            frame_mags.delete();
            cnt_m = 0; err_m = 1'b0; pend_m = 1'b0; pk_idx_m = 0; pk_mag_m = 32'd0;
            check_val("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
            check_val("rst_tlast", {31'd0, m_tlast}, 32'd0);
            check_val("rst_tdata", m_tdata, 32'd0);
            check_val("rst_peak_valid", {31'd0, peak_valid}, 32'd0);
            check_val("rst_peak_idx", {30'd0, peak_idx}, 32'd0);
            check_val("rst_peak_mag", peak_mag, 32'd0);
            check_val("rst_frame_err", {31'd0, frame_err}, 32'd0);
        end else begin
            check_val("peak_valid", {31'd0, peak_valid}, {31'd0, pend_m});
            if (pend_m) begin
                pk_idx_m = pend_idx;
                pk_mag_m = pend_mag;
                peak_cycles.push_back(cyc);
                pend_m = 1'b0;
            end
            check_val("peak_idx", {30'd0, peak_idx}, pk_idx_m);
            check_val("peak_mag", peak_mag, pk_mag_m);
            check_val("frame_err", {31'd0, frame_err}, {31'd0, err_m});
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] w, input logic lst);
        logic acc;
        int   k;
        acc = 1'b0;
        k = 0;
        while (!acc && k < 50) begin
            cycle(1'b1, w, lst, 1'b1, 1'b0, 1'b0, acc);
            k++;
        end
        if (!acc) check_val("send_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    endtask

    task automatic do_reset();
        logic acc;
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [31:0] w;
        logic        vld, lst, rdy, rst;
        s_tvalid = 1'b0; s_tdata = 32'd0; s_tlast = 1'b0; m_tready = 1'b1; areset = 1'b1;
        @(negedge clk);
        do_reset();
        do_reset();
        check_val("tstrb", {28'd0, m_tstrb}, 32'h0000_000F);

        // Basic frame with a tie: peak stays at index 1.
        first_acc_cyc = -1; first_out_cyc = -1;
        send(32'h0003_0004, 1'b0);
        send(32'hFFFA_0008, 1'b0);
        send(32'h0000_0000, 1'b0);
        send(32'h000A_0000, 1'b1);
        idle(4);
        check_val("latency", first_out_cyc - first_acc_cyc, 32'd2);
        check_val("t1_peak_idx", {30'd0, peak_idx}, 32'd1);
        check_val("t1_peak_mag", peak_mag, 32'd100);
        check_val("t1_frame_err", {31'd0, frame_err}, 32'd0);

        // Extreme components.
        send(32'h8000_8000, 1'b0);
        send(32'h7FFF_8001, 1'b0);
        send(32'h0000_0001, 1'b0);
        send(32'h0002_0000, 1'b1);
        idle(4);
        check_val("ovf_peak_idx", {30'd0, peak_idx}, 32'd0);
        check_val("ovf_peak_mag", peak_mag, 32'h8000_0000);

        // Downstream stall for three cycles mid-frame.
        out_count = 0;
        send(32'h0001_0001, 1'b0);
        send(32'h0005_0002, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h0002_0007, 1'b0, 1'b0, 1'b0, 1'b1, acc);
            check_val("stall_no_accept", {31'd0, acc}, 32'd0);
        end
        send(32'h0002_0007, 1'b0);
        send(32'hFFFF_0003, 1'b1);
        idle(5);
        check_val("stall_count", out_count, 32'd4);
        check_val("stall_peak_idx", {30'd0, peak_idx}, 32'd2);
        check_val("stall_peak_mag", peak_mag, 32'd53);

        // Short frame: tlast on bin 2.
        send(32'h0001_0000, 1'b0);
        send(32'h0003_0000, 1'b0);
        send(32'h0002_0000, 1'b1);
        idle(4);
        check_val("short_err", {31'd0, frame_err}, 32'd1);
        check_val("short_peak_idx", {30'd0, peak_idx}, 32'd1);
        send(32'h0000_0001, 1'b0);
        send(32'h0000_0001, 1'b0);
        send(32'h0000_0004, 1'b0);
        send(32'h0000_0002, 1'b1);
        idle(4);
        check_val("short_err_sticky", {31'd0, frame_err}, 32'd1);
        check_val("after_short_idx", {30'd0, peak_idx}, 32'd2);
        check_val("after_short_mag", peak_mag, 32'd16);

        // Mid-frame reset, then a clean frame.
        send(32'h0009_0009, 1'b0);
        send(32'h0008_0008, 1'b0);
        do_reset();
        send(32'h0000_0002, 1'b0);
        send(32'h0000_0006, 1'b0);
        send(32'h0000_0006, 1'b0);
        send(32'h0000_0001, 1'b1);
        idle(4);
        check_val("rst_frame_idx", {30'd0, peak_idx}, 32'd1);
        check_val("rst_frame_mag", peak_mag, 32'd36);

        // Back-to-back frames with no gaps.
        out_count = 0; out_first = -1; peak_cycles.delete();
        for (int i = 0; i < 8; i++) begin
            w = {16'(i * 3 % 7), 16'(i)};
            send(w, (i % 4) == 3);
        end
        idle(5);
        check_val("b2b_count", out_count, 32'd8);
        check_val("b2b_no_bubble", out_last_c - out_first, 32'd7);
        check_val("b2b_pulses", peak_cycles.size(), 32'd2);
        if (peak_cycles.size() == 2)
            check_val("b2b_spacing", peak_cycles[1] - peak_cycles[0], 32'd4);

        // Randomized traffic with back-pressure, short/long frames and resets.
        for (int i = 0; i < 3000; i++) begin
            vld = ($urandom % 10) < 7;
            w = $urandom;
            if ($urandom % 2) w = {14'd0, w[17:16], 14'd0, w[1:0]};
            if (cnt_m == SIZE - 1) lst = ($urandom % 10) != 0;
            else lst = ($urandom % 20) == 0;
            rdy = ($urandom % 4) != 0;
            rst = ($urandom % 300) == 0;
            cycle(vld, w, lst, rdy, rst, 1'b0, acc);
        end
        idle(10);
        check_val("drain_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
